// File: rtl/approx_error_monitor.sv
// Error-metric monitor for the HERLOA approximate adder: compares each approximate sum
// against the exact sum and accumulates count / sum / max of the error distance per batch.
// Optional macro APPROX_ERR_SSE_EN adds the sse output (saturating sum of squared ED).
module approx_error_monitor #(
  parameter int N     = 16,
  parameter int K     = 9,
  parameter int CNT_W = 16,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  input  logic [N-1:0]       s_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [N:0]         max_ed,
  output logic [7:0]         cfg_k
`ifdef APPROX_ERR_SSE_EN
  ,
  output logic [2*ACC_W-1:0] sse
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_sum_ed;
  logic [N:0]       r_max_ed;
  logic             r_v1;
  logic [N:0]       r_exact;
  logic [N:0]       r_approx;

  logic             w_start_go;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_next_cnt;
  logic [N:0]       w_ed;

  function automatic logic [ACC_W-1:0] sat_add_acc(input logic [ACC_W-1:0] acc,
                                                   input logic [N:0] ed);
    logic [ACC_W:0] t;
    t = {1'b0, acc} + {{(ACC_W-N){1'b0}}, ed};
    return t[ACC_W] ? {ACC_W{1'b1}} : t[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign w_start_go = start && (r_state == S_IDLE);
  assign w_accept   = in_valid && r_in_ready;
  assign w_next_cnt = r_sample_cnt + CNT_W'(1);
  assign w_last     = w_accept && (w_next_cnt == r_target);

  // ED is an absolute difference: the approximate sum may overshoot the exact one.
  always_comb begin
    if (r_exact >= r_approx) begin
      w_ed = r_exact - r_approx;
    end else begin
      w_ed = r_approx - r_exact;
    end
  end

  // Batch control: in_ready drops the cycle after the final accept, done waits for S1 to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_target   <= {CNT_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= num_samples;
            if (num_samples == {CNT_W{1'b0}}) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!r_v1) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture full-width exact sum and zero-extended approximate sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_exact  <= {(N+1){1'b0}};
      r_approx <= {(N+1){1'b0}};
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_exact  <= {1'b0, a} + {1'b0, b};
        r_approx <= {1'b0, s_approx};
      end
    end
  end

`ifdef APPROX_ERR_SSE_EN
  logic [2*ACC_W-1:0] r_sse;
  logic [2*N+1:0]     w_sq;

  function automatic logic [2*ACC_W-1:0] sat_add_sse(input logic [2*ACC_W-1:0] acc,
                                                     input logic [2*N+1:0] sq);
    logic [2*ACC_W:0] t;
    t = {1'b0, acc} + {{(2*ACC_W-2*N-1){1'b0}}, sq};
    return t[2*ACC_W] ? {(2*ACC_W){1'b1}} : t[2*ACC_W-1:0];
  endfunction

  assign w_sq = w_ed * w_ed;

  // Stage 2 squared-error accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sse <= {(2*ACC_W){1'b0}};
    end else if (w_start_go) begin
      r_sse <= {(2*ACC_W){1'b0}};
    end else if (r_v1) begin
      r_sse <= sat_add_sse(r_sse, w_sq);
    end
  end

  assign sse = r_sse;
`endif

  // Stage 2 result update plus the acceptance counter; all cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_cnt <= {CNT_W{1'b0}};
      r_err_cnt    <= {CNT_W{1'b0}};
      r_sum_ed     <= {ACC_W{1'b0}};
      r_max_ed     <= {(N+1){1'b0}};
    end else if (w_start_go) begin
      r_sample_cnt <= {CNT_W{1'b0}};
      r_err_cnt    <= {CNT_W{1'b0}};
      r_sum_ed     <= {ACC_W{1'b0}};
      r_max_ed     <= {(N+1){1'b0}};
    end else begin
      if (w_accept) begin
        r_sample_cnt <= w_next_cnt;
      end
      if (r_v1) begin
        r_sum_ed <= sat_add_acc(r_sum_ed, w_ed);
        if (w_ed != {(N+1){1'b0}}) begin
          r_err_cnt <= sat_inc_cnt(r_err_cnt);
        end
        if (w_ed > r_max_ed) begin
          r_max_ed <= w_ed;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign sum_ed     = r_sum_ed;
  assign max_ed     = r_max_ed;
  assign cfg_k      = 8'(K);

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor: a cycle-level reference model checked every
// cycle, plus hand-computed expectations at the end of each batch.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, busy, done;
  logic [15:0] num_samples, a, b, s_approx;
  logic [15:0] sample_cnt, err_cnt;
  logic [39:0] sum_ed;
  logic [16:0] max_ed;
  logic [7:0]  cfg_k;
`ifdef APPROX_ERR_SSE_EN
  logic [79:0] sse;
`endif

  approx_error_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .s_approx(s_approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed), .cfg_k(cfg_k)
`ifdef APPROX_ERR_SSE_EN
    , .sse(sse)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ed_of(input logic [15:0] x, input logic [15:0] y, input logic [15:0] s);
    int ex, ap;
    ex = int'(x) + int'(y);
    ap = int'(s);
    return (ex > ap) ? ex - ap : ap - ex;
  endfunction

  // ---------------- reference model (expected outputs for the current cycle) ----------
  typedef struct { int due; int ed; } pend_t;
  pend_t q[$];
  int          cyc = 0;
  bit          m_armed = 1'b0;
  bit          e_in_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  int          e_scnt = 0, e_ecnt = 0, e_max = 0;
  longint      e_sum = 0, e_sse = 0;
  int          m_target = 0, m_done_at = -1;

  always @(posedge clk) begin
    bit acc, idle;
    acc  = in_valid && e_in_ready;
    idle = !e_busy && !e_done;
    if (rst) begin
      e_in_ready = 0; e_busy = 0; e_done = 0;
      e_scnt = 0; e_ecnt = 0; e_max = 0; e_sum = 0; e_sse = 0;
      m_target = 0; m_done_at = -1; m_armed = 1;
      q.delete();
    end else begin
      e_done = 0;
      if (idle && start) begin
        m_target = int'(num_samples);
        e_scnt = 0; e_ecnt = 0; e_max = 0; e_sum = 0; e_sse = 0;
        if (num_samples == 16'd0) e_done = 1;
        else begin e_busy = 1; e_in_ready = 1; end
      end else if (acc) begin
        e_scnt++;
        q.push_back('{cyc + 2, ed_of(a, b, s_approx)});
        if (e_scnt == m_target) begin
          e_in_ready = 0;
          m_done_at  = cyc + 3;
        end
      end
      for (int i = 0; i < q.size(); ) begin
        if (q[i].due == cyc + 1) begin
          e_sum += longint'(q[i].ed);
          e_sse += longint'(q[i].ed) * longint'(q[i].ed);
          if (q[i].ed != 0 && e_ecnt < 65535) e_ecnt++;
          if (q[i].ed > e_max) e_max = q[i].ed;
          q.delete(i);
        end else i++;
      end
      if (cyc + 1 == m_done_at) begin
        e_done = 1;
        e_busy = 0;
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_armed) begin
      chk("m_in_ready",   64'(in_ready),   64'(e_in_ready));
      chk("m_busy",       64'(busy),       64'(e_busy));
      chk("m_done",       64'(done),       64'(e_done));
      chk("m_sample_cnt", 64'(sample_cnt), 64'(e_scnt));
      chk("m_err_cnt",    64'(err_cnt),    64'(e_ecnt));
      chk("m_sum_ed",     64'(sum_ed),     64'(e_sum));
      chk("m_max_ed",     64'(max_ed),     64'(e_max));
`ifdef APPROX_ERR_SSE_EN
      chk("m_sse",        64'(sse),        64'(e_sse));
`endif
    end
  end

  // ---------------- stimulus ---------------------------------------------------------
  logic [15:0] sa[8], sb[8], ss[8];
  int last_acc_cyc, done_cyc;

  task automatic set_s(input int i, input logic [15:0] x, input logic [15:0] y, input logic [15:0] s);
    sa[i] = x; sb[i] = y; ss[i] = s;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle, input bit mid_start, input bit extra);
    int idx = 0;
    bit ph = 1'b1;
    for (int k = 0; k < 200 && idx < n; k++) begin
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      a = sa[idx]; b = sb[idx]; s_approx = ss[idx];
      start = mid_start && (k == 3);
      num_samples = 16'd7;
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx++;
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("feed_accepts", 64'(idx), 64'(n));
    if (extra) begin
      in_valid = 1'b1; a = sa[n]; b = sb[n]; s_approx = ss[n];
      @(negedge clk);
      chk("no_extra_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        done_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("done_seen", 64'(found), 64'd1);
  endtask

  task automatic chk_results(input string tag, input int sc, input int ec, input int se, input int mx);
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(sc));
    chk({tag, "_err_cnt"},    64'(err_cnt),    64'(ec));
    chk({tag, "_sum_ed"},     64'(sum_ed),     64'(se));
    chk({tag, "_max_ed"},     64'(max_ed),     64'(mx));
    chk({tag, "_busy_low"},   64'(busy),       64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = 16'd0; in_valid = 1'b0;
    a = 16'd0; b = 16'd0; s_approx = 16'd0;
    last_acc_cyc = 0; done_cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_sum_ed",   64'(sum_ed),   64'd0);
    chk("cfg_k",        64'(cfg_k),    64'd9);
    @(posedge clk); #1;

    // Exact match: ED 0
    set_s(0, 16'h00FF, 16'h00FF, 16'h01FE);
    set_s(1, 16'h0001, 16'h0001, 16'h0000);
    do_start(16'd1); feed(1, 1'b0, 1'b0, 1'b1); wait_done();
    chk_results("t1", 1, 0, 0, 0);

    // Dropped carry-out: ED 0x10000
    set_s(0, 16'hFFFF, 16'h0001, 16'h0000);
    do_start(16'd1); feed(1, 1'b0, 1'b0, 1'b1); wait_done();
    chk_results("t2", 1, 1, 65536, 17'h10000);

    // Back-to-back, ED 5 / 0 / 300 (overshoot on the last)
    set_s(0, 16'd10, 16'd20, 16'd25);
    set_s(1, 16'h1234, 16'h1111, 16'h2345);
    set_s(2, 16'h0100, 16'h0000, 16'h022C);
    set_s(3, 16'h0003, 16'h0003, 16'h0000);
    do_start(16'd3); feed(3, 1'b0, 1'b0, 1'b1); wait_done();
    chk("t3_done_latency", 64'((done_cyc - last_acc_cyc >= 2) && (done_cyc - last_acc_cyc <= 3)), 64'd1);
    chk_results("t3", 3, 2, 305, 300);

    // Toggling valid with an ignored mid-batch start: ED 1 / 2 / 3 / 0
    set_s(0, 16'd1, 16'd1, 16'd1);
    set_s(1, 16'd4, 16'd4, 16'd6);
    set_s(2, 16'd0, 16'd0, 16'd3);
    set_s(3, 16'd7, 16'd8, 16'd15);
    set_s(4, 16'd9, 16'd9, 16'd0);
    do_start(16'd4); feed(4, 1'b1, 1'b1, 1'b1); wait_done();
    chk_results("t4", 4, 3, 6, 3);

    // Empty batch: done the cycle after start
    do_start(16'd0);
    @(negedge clk);
    chk("t5_done_next", 64'(done), 64'd1);
    chk_results("t5", 0, 0, 0, 0);

    // Reset after two accepted samples aborts the batch
    set_s(0, 16'd100, 16'd0, 16'd0);
    set_s(1, 16'd50, 16'd0, 16'd0);
    do_start(16'd4); feed(2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy",    64'(busy),       64'd0);
    chk("t6_rst_ready",   64'(in_ready),   64'd0);
    chk("t6_rst_cnt",     64'(sample_cnt), 64'd0);
    chk("t6_rst_sum",     64'(sum_ed),     64'd0);
    chk("t6_rst_max",     64'(max_ed),     64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;

    // Fresh batch after the abort: ED 7 / 9
    set_s(0, 16'd0, 16'd7, 16'd0);
    set_s(1, 16'd9, 16'd0, 16'h0012);
    set_s(2, 16'd1, 16'd1, 16'd0);
    do_start(16'd2); feed(2, 1'b0, 1'b0, 1'b1); wait_done();
    chk_results("t7", 2, 2, 16, 9);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
